// File: rtl/mpu_issue_seq.sv
// mpu_issue_seq: issues numbered work to enabled TPUs, registers each issue with the commit
// aggregator, bounds in-flight work, retires commits in order and supports a drain handshake.
module mpu_issue_seq #(
    parameter int NUM_TPU         = 1,
    parameter int WIDTH_ISSUE_NO  = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      I_Req,
    input  logic [NUM_TPU-1:0]        I_En_TPU,
    output logic                      O_Ack,
    input  logic                      I_Agg_Full,
    output logic [NUM_TPU-1:0]        O_Issue_Req,
    output logic [WIDTH_ISSUE_NO-1:0] O_Issue_No,
    output logic                      O_Agg_Req,
    output logic [NUM_TPU-1:0]        O_Agg_En_TPU,
    input  logic                      I_Commit_Req,
    input  logic [WIDTH_ISSUE_NO-1:0] I_Commit_No,
    input  logic                      I_Drain,
    output logic                      O_Drained,
    output logic [CW-1:0]             O_Num_Out,
    output logic                      O_Err
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH_ISSUE_NO-1:0] issue_no, commit_exp;
    logic [CW-1:0] cnt;
    logic issue, commit_ok, commit_bad;
    assign O_Ack      = I_Req & (state == RUN) & ~I_Drain & ~I_Agg_Full
                      & (cnt < CW'(MAX_OUTSTANDING)) & reset;
    assign issue      = O_Ack & |I_En_TPU;
    // a commit with nothing in flight is dropped without advancing the expected number
    assign commit_ok  = I_Commit_Req & (cnt != '0);
    assign commit_bad = I_Commit_Req & ((cnt == '0) | (I_Commit_No != commit_exp));
    assign O_Num_Out  = cnt;
    assign O_Drained  = (state == DONE);
    always_comb begin
        state_nxt = state;
        state_nxt = (state == RUN)   ? (I_Drain ? DRAIN : RUN) :
                    (state == DRAIN) ? ((cnt == '0) ? DONE : (I_Drain ? DRAIN : RUN)) :
                                       (I_Drain ? DONE : RUN);
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= RUN;
            issue_no     <= '0;
            commit_exp   <= '0;
            cnt          <= '0;
            O_Issue_Req  <= '0;
            O_Issue_No   <= '0;
            O_Agg_Req    <= 1'b0;
            O_Agg_En_TPU <= '0;
            O_Err        <= 1'b0;
        end else begin
            state        <= state_nxt;
            issue_no     <= issue ? issue_no + 1'b1 : issue_no;
            commit_exp   <= commit_ok ? commit_exp + 1'b1 : commit_exp;
            cnt          <= cnt + CW'(issue) - CW'(commit_ok);
            O_Issue_Req  <= issue ? I_En_TPU : '0;
            O_Issue_No   <= issue ? issue_no : O_Issue_No;
            O_Agg_Req    <= issue;
            O_Agg_En_TPU <= issue ? I_En_TPU : '0;
            O_Err        <= O_Err | commit_bad;
        end
    end
endmodule

// File: tb/tb_mpu_issue_seq.sv
// tb_mpu_issue_seq: scoreboard bench with an in-flight-queue reference model for mpu_issue_seq.
module tb_mpu_issue_seq;
    localparam int NT = 2, W = 3, M = 4, CW = 3;
    logic clock = 0, reset = 0;
    logic I_Req = 0, I_Agg_Full = 0, I_Commit_Req = 0, I_Drain = 0;
    logic [NT-1:0] I_En_TPU = 0;
    logic [W-1:0] I_Commit_No = 0;
    logic O_Ack, O_Agg_Req, O_Drained, O_Err;
    logic [NT-1:0] O_Issue_Req, O_Agg_En_TPU;
    logic [W-1:0] O_Issue_No;
    logic [CW-1:0] O_Num_Out;
    mpu_issue_seq #(.NUM_TPU(NT), .WIDTH_ISSUE_NO(W), .MAX_OUTSTANDING(M)) dut (
        .clock(clock), .reset(reset), .I_Req(I_Req), .I_En_TPU(I_En_TPU), .O_Ack(O_Ack),
        .I_Agg_Full(I_Agg_Full), .O_Issue_Req(O_Issue_Req), .O_Issue_No(O_Issue_No),
        .O_Agg_Req(O_Agg_Req), .O_Agg_En_TPU(O_Agg_En_TPU), .I_Commit_Req(I_Commit_Req),
        .I_Commit_No(I_Commit_No), .I_Drain(I_Drain), .O_Drained(O_Drained),
        .O_Num_Out(O_Num_Out), .O_Err(O_Err));
    always #5 clock = ~clock;
    typedef struct {int en; int no;} exp_t;
    exp_t sb[$];
    int inflight[$];
    int ctr = 0, mode = 0, errs = 0, checks = 0, last_no = 0;
    bit m_err = 0, mon_en = 0;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int front();
        return inflight.size() ? inflight[0] : 0;
    endfunction
    // one clock: drive at negedge, check against the model, then advance the model at posedge
    task automatic cyc(input bit req, input int en, input bit full, input bit creq,
                       input int cno, input bit drn, input bit rst_n, output bit acked);
        int old, nm;
        @(negedge clock);
        I_Req = req; I_En_TPU = NT'(en); I_Agg_Full = full; I_Commit_Req = creq;
        I_Commit_No = W'(cno); I_Drain = drn; reset = rst_n;
        #1;
        acked = req && mode == 0 && !drn && !full && inflight.size() < M && rst_n;
        check("ack", int'(O_Ack), int'(acked));
        check("num_out", int'(O_Num_Out), inflight.size());
        check("err", int'(O_Err), int'(m_err));
        check("drained", int'(O_Drained), int'(mode == 2));
        @(posedge clock);
        if (!rst_n) begin
            inflight.delete(); ctr = 0; m_err = 0; mode = 0; last_no = 0;
        end else begin
            old = inflight.size();
            nm = mode == 0 ? (drn ? 1 : 0) : mode == 1 ? (old == 0 ? 2 : (drn ? 1 : 0)) : (drn ? 2 : 0);
            if (creq) begin
                if (old == 0) m_err = 1;
                else begin
                    if (cno % 8 != inflight[0]) m_err = 1;
                    void'(inflight.pop_front());
                end
            end
            if (acked && en != 0) begin
                sb.push_back('{en, ctr});
                inflight.push_back(ctr);
                ctr = (ctr + 1) % 8;
            end
            mode = nm;
        end
    endtask
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (mon_en) begin
            if (O_Agg_Req) begin
                if (sb.size() == 0) check("spurious_pulse", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("issue_req", int'(O_Issue_Req), e.en);
                    check("agg_en", int'(O_Agg_En_TPU), e.en);
                    check("issue_no", int'(O_Issue_No), e.no);
                    last_no = e.no;
                end
            end else begin
                check("idle_issue_req", int'(O_Issue_Req), 0);
                check("hold_issue_no", int'(O_Issue_No), last_no);
                if (sb.size() != 0) begin
                    check("missing_pulse", 0, 1);
                    sb.delete();
                end
            end
        end
    end
    bit ak;
    task automatic idle(input bit drn); cyc(0, 0, 0, 0, 0, drn, 1, ak); endtask
    task automatic cm(input bit drn); cyc(0, 0, 0, 1, front(), drn, 1, ak); endtask
    task automatic issue(input int en);
        int n = 0;
        do begin cyc(1, en, 0, 0, 0, 0, 1, ak); n++; end while (!ak && n < 20);
        if (!ak) check("issue_timeout", 0, 1);
    endtask
    initial begin
        bit req = 0, drn = 0, full, creq;
        int en = 0, cno;
        repeat (2) @(posedge clock);
        mon_en = 1;
        cyc(1, 3, 0, 0, 0, 0, 0, ak);
        issue(3); cm(0); idle(0);
        for (int i = 0; i < 4; i++) issue(1 + i % 3);
        cyc(1, 2, 0, 0, 0, 0, 1, ak);
        cyc(1, 2, 0, 1, front(), 0, 1, ak);
        issue(2);
        repeat (3) cm(0);
        cyc(1, 1, 1, 0, 0, 0, 1, ak);
        issue(1);
        cyc(1, 3, 0, 1, front(), 0, 1, ak);
        check("simul_num_out_model", inflight.size(), 2);
        cyc(1, 0, 0, 0, 0, 0, 1, ak);
        repeat (2) cm(0);
        for (int i = 0; i < 9; i++) begin issue(1 + i % 3); cm(0); end
        idle(0);
        issue(1); cyc(0, 0, 0, 1, (front() + 5) % 8, 0, 1, ak); idle(0);
        cyc(0, 0, 0, 0, 0, 0, 0, ak);
        cyc(0, 0, 0, 1, 0, 0, 1, ak); idle(0);
        cyc(0, 0, 0, 0, 0, 0, 0, ak);
        issue(3); issue(1);
        cyc(1, 2, 0, 0, 0, 1, 1, ak);
        cyc(1, 2, 0, 0, 0, 1, 1, ak);
        cm(1); idle(1); cm(1); idle(1); idle(1); idle(1);
        idle(0); issue(2); cm(0);
        issue(1); issue(2); issue(3);
        cyc(1, 1, 0, 0, 0, 0, 0, ak);
        idle(0); idle(0);
        for (int i = 0; i < 600; i++) begin
            if (!req) begin req = $urandom_range(0, 1); en = $urandom_range(0, 3); end
            if ($urandom_range(0, 19) == 0) drn = ~drn;
            full = $urandom_range(0, 4) == 0;
            creq = inflight.size() ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) == 0;
            cno = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 7)) : front();
            cyc(req, en, full, creq, cno, drn, $urandom_range(0, 99) != 0, ak);
            if (ak) req = 0;
        end
        idle(0); idle(0);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
